afe_pulser: RTL and testbench

AFE_PULSER -- requirements
Module: afe_pulser

---
 rtl/afe_pulser_pkg.sv | 13 +
 rtl/afe_pulser_cnt.sv | 39 +++
 rtl/afe_pulser.sv | 74 +++++++
 tb/tb_afe_pulser.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/afe_pulser_pkg.sv
// Shared constants and types for the afe_pulser one-shot output pulser.
package afe_pulser_pkg;

    localparam int   WIDTH_BITS = 16;
    localparam logic OUT_IDLE   = 1'b0;
    localparam logic OUT_ACTIVE = 1'b1;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_e;

endpackage

// File: rtl/afe_pulser_cnt.sv
// Pulse-length down-counter: loads width-1, decrements without wrapping, flags zero.
module afe_pulser_cnt #(
    parameter int WIDTH_BITS = afe_pulser_pkg::WIDTH_BITS
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr_i,
    input  logic                  load_i,
    input  logic [WIDTH_BITS-1:0] load_val_i,
    input  logic                  dec_i,
    output logic                  zero_o
);

    logic [WIDTH_BITS-1:0] count_q, count_d;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (load_i) begin
            count_d = load_val_i - WIDTH_BITS'(1);
        end else if (dec_i && (count_q != '0)) begin
            count_d = count_q - WIDTH_BITS'(1);
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
        if (!rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero_o = (count_q == '0);

endmodule

// File: rtl/afe_pulser.sv
// Triggered pulser: emits a registered pulse of 'width' clocks with selectable polarity.
module afe_pulser #(
    parameter int WIDTH_BITS = afe_pulser_pkg::WIDTH_BITS
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  io_rst,
    input  logic                  trig,
    input  logic                  y0,
    input  logic [WIDTH_BITS-1:0] width,
    output logic                  out
);

    import afe_pulser_pkg::*;

    state_e state_q, state_d;
    logic   out_q, out_d;
    logic   cnt_clr, cnt_load, cnt_dec, cnt_zero;

    afe_pulser_cnt #(
        .WIDTH_BITS (WIDTH_BITS)
    ) u_cnt (
        .clk        (clk),
        .rst        (rst),
        .clr_i      (cnt_clr),
        .load_i     (cnt_load),
        .load_val_i (width),
        .dec_i      (cnt_dec),
        .zero_o     (cnt_zero)
    );

    always_comb begin
        state_d  = state_q;
        cnt_clr  = 1'b0;
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;
        if (io_rst) begin
            state_d = ST_IDLE;
            cnt_clr = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (trig && (width != '0)) begin
                        state_d  = ST_BUSY;
                        cnt_load = 1'b1;
                    end
                end
                ST_BUSY: begin
                    // Triggers are ignored here, including on the last active cycle.
                    if (cnt_zero) begin
                        state_d = ST_IDLE;
                    end else begin
                        cnt_dec = 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
        out_d = y0 ^ ((state_d == ST_BUSY) ? OUT_ACTIVE : OUT_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            out_q   <= OUT_IDLE;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
        end
    end

    assign out = out_q;

endmodule

// File: tb/tb_afe_pulser.sv
// Directed bench for afe_pulser: expected out levels are queued per edge and checked after it.
module tb_afe_pulser;

    import afe_pulser_pkg::*;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  io_rst;
    logic                  trig;
    logic                  y0;
    logic [WIDTH_BITS-1:0] width;
    logic                  out;

    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;

    typedef struct {
        logic  exp;
        string tag;
    } exp_t;

    exp_t sb_q[$];

    afe_pulser #(
        .WIDTH_BITS (WIDTH_BITS)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .io_rst (io_rst),
        .trig   (trig),
        .y0     (y0),
        .width  (width),
        .out    (out)
    );

    always #5 clk = ~clk;

    task automatic check(input logic [31:0] obs, input logic [31:0] exp, input string tag);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Queue the expected level for the coming edge, then compare it 1 ns after that edge.
    task automatic tick(input logic exp, input string tag);
        exp_t e;
        sb_q.push_back('{exp: exp, tag: tag});
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        check({31'd0, out}, {31'd0, e.exp}, e.tag);
    endtask

    task automatic idle(input int n, input string tag);
        trig = 1'b0;
        repeat (n) tick(y0, tag);
    endtask

    // Trigger a pulse of w cycles and check every active edge plus the first idle edge.
    task automatic fire(input int w, input string tag);
        width = WIDTH_BITS'(w);
        trig  = 1'b1;
        tick(~y0, tag);
        trig = 1'b0;
        repeat (w - 1) tick(~y0, tag);
        tick(y0, {tag, "_end"});
    endtask

    initial begin
        int n;

        rst    = 1'b0;
        io_rst = 1'b1;
        trig   = 1'b0;
        y0     = 1'b0;
        width  = WIDTH_BITS'(12);

        // Reset holds out low regardless of trig, y0 and io_rst.
        tick(1'b0, "rst");
        trig = 1'b1;
        tick(1'b0, "rst_trig");
        trig = 1'b0;
        y0   = 1'b1;
        tick(1'b0, "rst_y0");
        y0     = 1'b0;
        io_rst = 1'b0;
        trig   = 1'b1;
        tick(1'b0, "rst_prio");
        trig = 1'b0;
        tick(1'b0, "rst");

        // Out of reset but io_rst still asserted: triggers blocked.
        rst    = 1'b1;
        io_rst = 1'b1;
        tick(1'b0, "iorst");
        trig = 1'b1;
        tick(1'b0, "iorst_trig");
        trig = 1'b0;
        repeat (2) tick(1'b0, "iorst");
        trig = 1'b1;
        tick(1'b0, "iorst_trig2");
        trig   = 1'b0;
        io_rst = 1'b0;
        idle(3, "idle");

        fire(12, "w12");
        idle(5, "idle");
        fire(7, "w7");
        idle(5, "idle");

        for (int w = 6; w >= 1; w--) begin
            fire(w, "wseq");
            idle(9 - w, "wseq_idle");
        end

        width = '0;
        trig  = 1'b1;
        tick(1'b0, "w0");
        idle(3, "w0_after");

        // Second trigger and width change mid-pulse must not disturb it.
        width = WIDTH_BITS'(12);
        trig  = 1'b1;
        tick(1'b1, "busy");
        trig = 1'b0;
        repeat (4) tick(1'b1, "busy");
        width = WIDTH_BITS'(3);
        trig  = 1'b1;
        tick(1'b1, "busy_trig");
        trig = 1'b0;
        repeat (6) tick(1'b1, "busy");
        tick(1'b0, "busy_end");
        idle(2, "idle");

        // Trigger on the final active cycle is dropped; one cycle later it is taken.
        width = WIDTH_BITS'(4);
        trig  = 1'b1;
        tick(1'b1, "final");
        trig = 1'b0;
        repeat (3) tick(1'b1, "final");
        width = WIDTH_BITS'(2);
        trig  = 1'b1;
        tick(1'b0, "final_trig");
        tick(1'b1, "respaced");
        trig = 1'b0;
        tick(1'b1, "respaced");
        tick(1'b0, "respaced_end");
        idle(2, "idle");

        // Inverted polarity, including a polarity flip in the middle of a pulse.
        y0 = 1'b1;
        tick(1'b1, "y0_idle");
        idle(2, "y0_idle");
        fire(3, "inv");
        idle(2, "inv_idle");
        width = WIDTH_BITS'(5);
        trig  = 1'b1;
        tick(1'b0, "inv_mid");
        trig = 1'b0;
        tick(1'b0, "inv_mid");
        y0 = 1'b0;
        tick(1'b1, "y0_flip");
        repeat (2) tick(1'b1, "y0_flip");
        tick(1'b0, "flip_end");

        // io_rst truncates a pulse and blocks a simultaneous trigger.
        width = WIDTH_BITS'(20);
        trig  = 1'b1;
        tick(1'b1, "trunc");
        trig = 1'b0;
        repeat (4) tick(1'b1, "trunc");
        io_rst = 1'b1;
        trig   = 1'b1;
        tick(1'b0, "trunc_cut");
        io_rst = 1'b0;
        idle(3, "trunc_after");
        io_rst = 1'b1;
        trig   = 1'b1;
        tick(1'b0, "iorst_idle_trig");
        io_rst = 1'b0;
        idle(2, "idle");

        // Reset release: idle level follows y0, and a trigger on the first edge is taken.
        rst = 1'b0;
        y0  = 1'b1;
        tick(1'b0, "rst_inv");
        rst = 1'b1;
        tick(1'b1, "rel_idle");
        y0  = 1'b0;
        rst = 1'b0;
        tick(1'b0, "rst2");
        rst   = 1'b1;
        width = WIDTH_BITS'(3);
        trig  = 1'b1;
        tick(1'b1, "rel_trig");
        trig = 1'b0;
        repeat (2) tick(1'b1, "rel_trig");
        tick(1'b0, "rel_end");
        idle(2, "idle");

        // Maximum width: exact length with no counter wrap.
        width = '1;
        trig  = 1'b1;
        tick(1'b1, "max_start");
        trig = 1'b0;
        n    = 1;
        for (int i = 0; i < 70000; i++) begin
            @(posedge clk);
            #1;
            if (out !== 1'b1) break;
            n++;
        end
        check(32'(n), 32'd65535, "max_len");
        check({31'd0, out}, 32'd0, "max_end");
        idle(2, "idle");

        check(32'(sb_q.size()), 32'd0, "sb_empty");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
